// File: rtl/sys_time_ctrl_if.sv
// Control/status bundle between the sync logic and the system time controller.
// The controller takes the slave side; the sync logic or sequencer takes master.
interface sys_time_ctrl_if #(
  parameter int TIME_W = 64
);
  logic              locked;
  logic              set_valid;
  logic [TIME_W-1:0] set_time;
  logic              set_ready;
  logic              evt_arm;
  logic [TIME_W-1:0] evt_time;
  logic              evt_pending;
  logic              evt_fire;
  logic              clr_lock_lost;
  logic [TIME_W-1:0] sys_time;
  logic              running;
  logic              tick;
  logic              lock_lost;

  modport master (
    output locked, set_valid, set_time, evt_arm, evt_time, clr_lock_lost,
    input  set_ready, evt_pending, evt_fire, sys_time, running, tick, lock_lost
  );

  modport slave (
    input  locked, set_valid, set_time, evt_arm, evt_time, clr_lock_lost,
    output set_ready, evt_pending, evt_fire, sys_time, running, tick, lock_lost
  );
endinterface

// File: rtl/sys_time_ctrl.sv
// System time counter controller: lock qualification, time-set handshake,
// periodic tick, one-shot compare event and sticky lock-loss flag.
module sys_time_ctrl #(
  parameter int TIME_W      = 64,
  parameter int PERIOD      = 512,
  parameter int LOCK_CYCLES = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  sys_time_ctrl_if.slave  bus
);
  localparam logic [0:0] WAIT_LOCK = 1'b0;
  localparam logic [0:0] RUN       = 1'b1;
  localparam int         TICK_W    = $clog2(PERIOD);
  localparam logic [4:0] LOCK_LAST = 5'(LOCK_CYCLES - 1);

  logic [0:0]        state_q,     state_d;
  logic [4:0]        lock_cnt_q,  lock_cnt_d;
  logic [TIME_W-1:0] time_q,      time_d;
  logic [TIME_W-1:0] cmp_q,       cmp_d;
  logic              pending_q,   pending_d;
  logic              fire_q,      fire_d;
  logic              lock_lost_q, lock_lost_d;
  logic              running_s;
  logic              lost_set_s;

  assign running_s = (state_q == RUN);

  // Lock qualification, time counting/loading and lock-loss detection.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    time_d     = time_q;
    lost_set_s = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        if (bus.locked) begin
          if (lock_cnt_q == LOCK_LAST) begin
            state_d    = RUN;
            lock_cnt_d = 5'd0;
          end else begin
            lock_cnt_d = lock_cnt_q + 5'd1;
          end
        end else begin
          lock_cnt_d = 5'd0;
        end
      end
      RUN: begin
        if (!bus.locked) begin
          // Freeze time; a set offered on this edge is dropped.
          state_d    = WAIT_LOCK;
          lock_cnt_d = 5'd0;
          lost_set_s = 1'b1;
        end else if (bus.set_valid) begin
          time_d = bus.set_time;
        end else begin
          time_d = time_q + TIME_W'(1);
        end
      end
      default: begin
        state_d    = WAIT_LOCK;
        lock_cnt_d = 5'd0;
      end
    endcase

    if (lost_set_s) begin
      lock_lost_d = 1'b1;
    end else if (bus.clr_lock_lost) begin
      lock_lost_d = 1'b0;
    end else begin
      lock_lost_d = lock_lost_q;
    end
  end

  // Compare event: arm captures the compare value, fire retires the pending event.
  always_comb begin
    fire_d = pending_q && running_s && (time_q >= cmp_q);
    cmp_d  = cmp_q;
    if (bus.evt_arm) begin
      pending_d = 1'b1;
      cmp_d     = bus.evt_time;
    end else if (fire_d) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= WAIT_LOCK;
      lock_cnt_q  <= 5'd0;
      time_q      <= {TIME_W{1'b0}};
      cmp_q       <= {TIME_W{1'b0}};
      pending_q   <= 1'b0;
      fire_q      <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      time_q      <= time_d;
      cmp_q       <= cmp_d;
      pending_q   <= pending_d;
      fire_q      <= fire_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign bus.sys_time    = time_q;
  assign bus.running     = running_s;
  assign bus.set_ready   = running_s;
  assign bus.evt_pending = pending_q;
  assign bus.evt_fire    = fire_q;
  assign bus.lock_lost   = lock_lost_q;
  assign bus.tick        = running_s && (time_q[TICK_W-1:0] == {TICK_W{1'b0}});
endmodule

// File: tb/tb_sys_time_ctrl.sv
// Directed and randomized bench for sys_time_ctrl against a cycle-level
// reference model derived from the behavioural rules of the block.
module tb_sys_time_ctrl;
  localparam int TW = 64;
  localparam int P  = 512;
  localparam int LC = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sys_time_ctrl_if #(.TIME_W(TW)) bus();

  sys_time_ctrl #(.TIME_W(TW), .PERIOD(P), .LOCK_CYCLES(LC)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Reference model state: running is "at least LC consecutive lock samples".
  logic [TW-1:0] m_time;
  logic [TW-1:0] m_cmp;
  int            m_streak;
  bit            m_pending;
  bit            m_fire;
  bit            m_lost;
  int            checks = 0;
  int            errors = 0;

  function automatic bit m_run();
    return (m_streak >= LC);
  endfunction

  task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit run;
    bit fire_n;
    if (rst) begin
      m_time = '0; m_cmp = '0; m_streak = 0;
      m_pending = 1'b0; m_fire = 1'b0; m_lost = 1'b0;
    end else begin
      run    = m_run();
      fire_n = m_pending && run && (m_time >= m_cmp);
      if (run && bus.locked) m_time = bus.set_valid ? bus.set_time : m_time + 64'd1;
      if (run && !bus.locked) m_lost = 1'b1;
      else if (bus.clr_lock_lost) m_lost = 1'b0;
      if (bus.evt_arm) begin
        m_pending = 1'b1;
        m_cmp     = bus.evt_time;
      end else if (fire_n) begin
        m_pending = 1'b0;
      end
      m_fire   = fire_n;
      m_streak = bus.locked ? ((m_streak < LC) ? m_streak + 1 : LC) : 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("sys_time",    bus.sys_time,            m_time);
    chk("running",     64'(bus.running),        64'(m_run()));
    chk("set_ready",   64'(bus.set_ready),      64'(m_run()));
    chk("tick",        64'(bus.tick),           64'(m_run() && (m_time % P == 0)));
    chk("evt_pending", 64'(bus.evt_pending),    64'(m_pending));
    chk("evt_fire",    64'(bus.evt_fire),       64'(m_fire));
    chk("lock_lost",   64'(bus.lock_lost),      64'(m_lost));
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_once(input logic [TW-1:0] t);
    bus.set_valid = 1'b1; bus.set_time = t;
    step();
    bus.set_valid = 1'b0;
  endtask

  task automatic arm_once(input logic [TW-1:0] t);
    bus.evt_arm = 1'b1; bus.evt_time = t;
    step();
    bus.evt_arm = 1'b0;
  endtask

  initial begin
    m_time = '0; m_cmp = '0; m_streak = 0;
    m_pending = 1'b0; m_fire = 1'b0; m_lost = 1'b0;
    rst = 1'b1;
    bus.locked = 1'b0; bus.set_valid = 1'b0; bus.set_time = '0;
    bus.evt_arm = 1'b0; bus.evt_time = '0; bus.clr_lock_lost = 1'b0;

    // Reset start-up and tick at 0, 512, 1024.
    cyc(3);
    rst = 1'b0; bus.locked = 1'b1;
    cyc(1030);

    // Set held through WAIT_LOCK, then a back-to-back set.
    rst = 1'b1; step(); rst = 1'b0;
    bus.set_valid = 1'b1; bus.set_time = 64'h1000;
    cyc(5);
    bus.set_time = 64'h2000;
    step();
    bus.set_valid = 1'b0;
    cyc(3);

    // Future and past event arms.
    set_once(64'd100);
    arm_once(64'd110);
    cyc(15);
    set_once(64'd100);
    arm_once(64'd5);
    cyc(4);

    // Sets jumping across a pending compare value.
    set_once(64'd1000);
    arm_once(64'd5000);
    set_once(64'd6000);
    cyc(4);
    arm_once(64'd5000);
    set_once(64'd10);
    cyc(10);
    set_once(64'd4990);
    cyc(20);

    // Lock loss with an event pending, recovery, flag clear.
    arm_once(64'd1000);
    set_once(64'd300);
    bus.locked = 1'b0; step();
    bus.locked = 1'b1; cyc(8);
    bus.clr_lock_lost = 1'b1; step();
    bus.clr_lock_lost = 1'b0; cyc(2);
    // Lock loss and clear on the same edge: flag stays set.
    bus.locked = 1'b0; bus.clr_lock_lost = 1'b1; step();
    bus.locked = 1'b1; bus.clr_lock_lost = 1'b0; cyc(6);
    bus.clr_lock_lost = 1'b1; step();
    bus.clr_lock_lost = 1'b0; cyc(1200);

    // Wrap through 2^64-1.
    set_once(64'hFFFF_FFFF_FFFF_FFFE);
    cyc(4);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      rst               = ($urandom_range(0, 399) == 0);
      bus.locked        = ($urandom_range(0, 99) < 97);
      bus.set_valid     = ($urandom_range(0, 99) < 6);
      case ($urandom_range(0, 2))
        0:       bus.set_time = {$urandom, $urandom};
        1:       bus.set_time = {$urandom, $urandom} & ~64'(P - 1);
        default: bus.set_time = m_time + 64'($urandom_range(0, 60)) - 64'd30;
      endcase
      bus.evt_arm       = ($urandom_range(0, 99) < 5);
      bus.evt_time      = m_time + 64'($urandom_range(0, 40)) - 64'd10;
      bus.clr_lock_lost = ($urandom_range(0, 99) < 3);
      step();
    end
    rst = 1'b0; bus.set_valid = 1'b0; bus.evt_arm = 1'b0; bus.clr_lock_lost = 1'b0;
    bus.locked = 1'b1;

    // Reset mid-run with an event pending.
    cyc(6);
    arm_once(m_time + 64'd1000);
    cyc(3);
    rst = 1'b1; step();
    rst = 1'b0; cyc(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
